// File: rtl/seq_alu_exec_pkg.sv
// Shared definitions for the sequential execute-stage ALU.
// Holds the alufunc operation codes, the FSM state encoding and a shift-op helper.
// Imported by seq_alu_exec and its testbench.
package seq_alu_exec_pkg;

  // alufunc codes produced by the ALU control decoder
  localparam logic [3:0] ALU_PLUS = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  // 14 and 15 are unassigned and complete as result=0, br_taken=0

  typedef enum logic [1:0] {
    EXS_IDLE  = 2'd0,
    EXS_SHIFT = 2'd1,
    EXS_DONE  = 2'd2
  } exs_state_e;

  function automatic logic is_shift_op(input logic [3:0] f);
    return (f == ALU_SLL) || (f == ALU_SRL) || (f == ALU_SRA);
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative shifter: loads an operand and shift amount, then shifts up to
// SHIFT_STEP bits per cycle until the count is exhausted.
// zero_o reports that the count will be zero after the current cycle.
module seq_alu_shifter #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     dir_i,    // 0: left, 1: right
  input  logic                     arith_i,  // right shifts replicate the sign bit
  input  logic [WIDTH-1:0]         din_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     zero_o
);
  import seq_alu_exec_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d, amt;
  logic             dir_q, fill_q;

  // Step size this cycle: never shift past the remaining count
  always_comb begin
    amt = (cnt_q < STEP) ? cnt_q : STEP;
  end

  // Next shift value and count; fill bit is captured from the original operand at load
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = din_i;
      cnt_d = shamt_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - amt;
      if (dir_q) begin
        sh_d = (sh_q >> amt) | (fill_q ? ~({WIDTH{1'b1}} >> amt) : '0);
      end else begin
        sh_d = sh_q << amt;
      end
    end
  end

  // Shift register, count and mode state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        dir_q  <= dir_i;
        fill_q <= arith_i & din_i[WIDTH-1];
      end
    end
  end

  assign dout_o = sh_q;
  assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/seq_alu_exec.sv
// Execute-stage ALU: single-cycle ops complete in 1 cycle, shifts take 1+ceil(shamt/SHIFT_STEP).
// One op in flight; in_ready only in IDLE; result held in DONE until out_ready.
// Branch codes return br_taken with result=0; unknown codes return zeros.
module seq_alu_exec #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alufunc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             br_taken,
  output logic             busy
);
  import seq_alu_exec_pkg::*;

  localparam int CW = $clog2(WIDTH);

  exs_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, sh_dout;
  logic             br_q, br_d, sel_sh_q;
  logic             accept, op_shift, sh_load, sh_zero;

  assign accept   = in_valid && (state_q == EXS_IDLE);
  assign op_shift = is_shift_op(alufunc);

  // Single-cycle datapath and branch evaluation
  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    case (alufunc)
      ALU_PLUS: res_d = op_a + op_b;
      ALU_SUB:  res_d = op_a - op_b;
      ALU_XOR:  res_d = op_a ^ op_b;
      ALU_OR:   res_d = op_a | op_b;
      ALU_AND:  res_d = op_a & op_b;
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_BEQ:  br_d  = (op_a == op_b);
      ALU_BNE:  br_d  = (op_a != op_b);
      ALU_BLT:  br_d  = ($signed(op_a) < $signed(op_b));
      ALU_BGE:  br_d  = ($signed(op_a) >= $signed(op_b));
      default: begin
        res_d = '0;
        br_d  = 1'b0;
      end
    endcase
  end

  seq_alu_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .dir_i   (alufunc != ALU_SLL),
    .arith_i (alufunc == ALU_SRA),
    .din_i   (op_a),
    .shamt_i (op_b[CW-1:0]),
    .dout_o  (sh_dout),
    .zero_o  (sh_zero)
  );

  // Next-state logic; shifts with a zero amount go straight to DONE
  always_comb begin
    state_d = state_q;
    sh_load = 1'b0;
    case (state_q)
      EXS_IDLE: begin
        if (accept) begin
          if (op_shift) begin
            sh_load = 1'b1;
            state_d = sh_zero ? EXS_DONE : EXS_SHIFT;
          end else begin
            state_d = EXS_DONE;
          end
        end
      end
      EXS_SHIFT: if (sh_zero) state_d = EXS_DONE;
      EXS_DONE:  if (out_ready) state_d = EXS_IDLE;
      default:   state_d = EXS_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EXS_IDLE;
    else     state_q <= state_d;
  end

  // Output registers, captured only at acceptance so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      br_q     <= 1'b0;
      sel_sh_q <= 1'b0;
    end else if (accept) begin
      res_q    <= op_shift ? '0 : res_d;
      br_q     <= op_shift ? 1'b0 : br_d;
      sel_sh_q <= op_shift;
    end
  end

  assign in_ready  = (state_q == EXS_IDLE);
  assign out_valid = (state_q == EXS_DONE);
  assign busy      = (state_q != EXS_IDLE);
  assign result    = sel_sh_q ? sh_dout : res_q;
  assign br_taken  = br_q;

endmodule
